bus_xbar: RTL and testbench
===========================

Name: bus_xbar

Overview:
Parametrised successor to the single-master, fixed eight-slave bus decoder.
- Connects NUM_MASTERS bus masters (e.g. CPU instruction and data ports) to NUM_SLAVES slaves (RAM, ROM, flash, UART, digseg, …).
- Arbitration is round-robin. Address decode uses a top-address-bit field.
- Provides a registered request/ack handshake and error responses for unmapped addresses.
- Sits between the CPU bus interfaces and the peripheral controllers in the top-level bus wrapper.

Parameters:
NUM_MASTERS, 2, number of masters (1..4)
NUM_SLAVES, 8, number of slaves (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
SEL_HI, 31, MSB of slave-index field in address
SEL_LO, 28, LSB of slave-index field in address
TIMEOUT, 255, max wait cycles for slave ack (used only with BUS_XBAR_TIMEOUT_EN)
ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m_stb_i  in  NUM_MASTERS  per-master request strobe
m_addr_i  in  NUM_MASTERS*ADDR_W  flattened master addresses
m_data_i  in  NUM_MASTERS*DATA_W  flattened write data
m_we_i  in  NUM_MASTERS  write enable
m_sel_i  in  NUM_MASTERS*DATA_W/8  byte enables
m_data_o  out  DATA_W  read data, shared; valid with m_ack_o
m_ack_o  out  NUM_MASTERS  one-hot completion pulse
m_err_o  out  NUM_MASTERS  one-hot error pulse, coincident with m_ack_o
s_stb_o  out  NUM_SLAVES  one-hot slave strobe
s_addr_o  out  ADDR_W  latched address, broadcast to all slaves
s_data_o  out  DATA_W  latched write data, broadcast
s_we_o  out  1  latched write enable
s_sel_o  out  DATA_W/8  latched byte enables
s_data_i  in  NUM_SLAVES*DATA_W  flattened slave read data
s_ack_i  in  NUM_SLAVES  slave ack

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer = master 0.
- IDLE:
  - Pick the granted master round-robin, starting search at pointer.
  - Latch that master's addr, data, we, sel and index; idx = addr[SEL_HI:SEL_LO].
  - If idx < NUM_SLAVES: go to ACTIVE, assert s_stb_o[idx] at the edge.
  - If idx >= NUM_SLAVES: go to RESP with err=1, rdata=ERR_DATA; no slave strobe.
  - No request pending: stay in IDLE.
- ACTIVE:
  - s_stb_o[idx] and the latched s_* signals are held constant.
  - On s_ack_i[idx]=1: latch s_data_i slice idx (ERR_DATA not used), drop strobe at the edge, go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP (one cycle):
  - m_ack_o[grant]=1, m_data_o = latched data, m_err_o[grant] = err.
  - Next state IDLE; pointer = grant+1, wrapping modulo NUM_MASTERS.
- Latency:
  - Request seen in cycle 0; slave strobe in cycle 1.
  - Slave acking in cycle 1 gives master ack in cycle 2; minimum round trip is 3 cycles.
  - Each extra slave wait cycle adds 1.
- Master rules:
  - Hold stb and attributes stable until ack.
  - A stb still high in the IDLE cycle after RESP is a new request.
- Fairness: round-robin guarantees each waiting master service within NUM_MASTERS transactions.
- Outputs outside RESP: m_data_o = 0 and m_ack_o/m_err_o = 0.
- Reset mid-transaction: strobe drops at that edge and state returns to IDLE; any late slave ack is ignored.
- NUM_MASTERS=1: arbitration degenerates to a fixed grant; pointer stays 0.

Optional Feature:
BUS_XBAR_TIMEOUT_EN:
- Defined:
  - An 8..16-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When it reaches TIMEOUT with no ack: drop strobe, go to RESP with err=1, data=ERR_DATA.
  - An ack arriving in the same cycle as timeout wins (normal completion).
- Undefined: no counter; ACTIVE waits indefinitely.

Decomposition:
- Shared package/defines: state encoding (IDLE/ACTIVE/RESP), ERR_DATA default, slave index map constants (RAM=0, ROM=1, FLASH=2, VGA=3, UART=4, UART_STAT=5, DIGSEG=6, PS2=7).
- Sub-module rr_arbiter: request vector plus pointer in, one-hot grant plus index out; purely combinational.

Test Plan:
- Single master 0, read addr 0x0000_0010, slave 0 acks in the strobe cycle with 0x1234_5678 -> m_ack_o=01 in cycle 2, m_data_o=0x1234_5678, m_err_o=0.
- Both masters request continuously to slave 1 -> grants alternate 0,1,0,1; s_stb_o[1] never overlaps two transactions.
- Master 1 writes addr 0x9000_0000 (idx 9) with NUM_SLAVES=8 -> no s_stb_o, m_ack_o=10, m_err_o=10, m_data_o=0xDEAD_BEEF.
- rst asserted while ACTIVE, then slave ack 2 cycles later -> all outputs 0, no m_ack_o pulse.
- With BUS_XBAR_TIMEOUT_EN and TIMEOUT=4, slave never acks -> strobe drops, err ack to master with 0xDEAD_BEEF.
- Slave 3 acks while slave 2 is selected -> ignored; completion only on slave 2 ack.

Source files
------------

// File: rtl/bus_xbar_pkg.sv
// Shared types and constants for the bus crossbar: FSM state encoding, error read data
// and the slave index map of the SoC.
package bus_xbar_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic [31:0] ErrDataDefault = 32'hDEAD_BEEF;

  localparam int unsigned SlvRam      = 0;
  localparam int unsigned SlvRom      = 1;
  localparam int unsigned SlvFlash    = 2;
  localparam int unsigned SlvVga      = 3;
  localparam int unsigned SlvUart     = 4;
  localparam int unsigned SlvUartStat = 5;
  localparam int unsigned SlvDigseg   = 6;
  localparam int unsigned SlvPs2      = 7;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xbar_if.sv
// Flattened multi-master / multi-slave bus bundle. The crossbar takes the master side
// through modport master and the slave side through modport slave.
interface bus_xbar_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 8,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) ();

  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr_i;
  logic [NUM_MASTERS*DATA_W-1:0]     m_data_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel_i;
  logic [DATA_W-1:0]                 m_data_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;

  logic [NUM_SLAVES-1:0]             s_stb_o;
  logic [ADDR_W-1:0]                 s_addr_o;
  logic [DATA_W-1:0]                 s_data_o;
  logic                              s_we_o;
  logic [DATA_W/8-1:0]               s_sel_o;
  logic [NUM_SLAVES*DATA_W-1:0]      s_data_i;
  logic [NUM_SLAVES-1:0]             s_ack_i;

  modport master (
    input  m_stb_i, m_addr_i, m_data_i, m_we_i, m_sel_i,
    output m_data_o, m_ack_o, m_err_o
  );

  modport slave (
    output s_stb_o, s_addr_o, s_data_o, s_we_o, s_sel_o,
    input  s_data_i, s_ack_i
  );

endinterface

// File: rtl/bus_xbar_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module bus_xbar_rr_arbiter
  import bus_xbar_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && (j == cand) && req_i[j]) begin
          found    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = IdxW'(j);
        end
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/bus_xbar.sv
// Round-robin N-master / M-slave bus crossbar with registered strobe/ack handshake and
// error responses for unmapped addresses. Define BUS_XBAR_TIMEOUT_EN for a slave timeout.
module bus_xbar
  import bus_xbar_pkg::*;
#(
  parameter int unsigned       NUM_MASTERS = 2,
  parameter int unsigned       NUM_SLAVES  = 8,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       SEL_HI      = 31,
  parameter int unsigned       SEL_LO      = 28,
  parameter int unsigned       TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ErrDataDefault)
) (
  input  logic       clk,
  input  logic       rst,
  bus_xbar_if.master m_bus,
  bus_xbar_if.slave  s_bus
);

  localparam int unsigned MIdxW = idx_width(NUM_MASTERS);
  localparam int unsigned SelW  = SEL_HI - SEL_LO + 1;
  localparam int unsigned StrbW = DATA_W / 8;

  state_e                 state_q, state_d;
  logic [MIdxW-1:0]       ptr_q, ptr_d;
  logic [MIdxW-1:0]       gidx_q, gidx_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [NUM_SLAVES-1:0]  stb_q, stb_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic [StrbW-1:0]       sel_q, sel_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [MIdxW-1:0]       arb_idx;
  logic                   arb_valid;

  logic [ADDR_W-1:0]      req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic                   req_we;
  logic [StrbW-1:0]       req_sel;
  logic [SelW-1:0]        sel_field;
  logic                   req_hit;
  logic [NUM_SLAVES-1:0]  req_dec;

  logic                   ack_hit;
  logic [DATA_W-1:0]      slv_rdata;
  logic                   tmo_hit;

  bus_xbar_rr_arbiter #(
    .N    (NUM_MASTERS),
    .IdxW (MIdxW)
  ) u_arb (
    .req_i   (m_bus.m_stb_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Attributes of the granted master.
  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_we    = 1'b0;
    req_sel   = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (arb_gnt[m]) begin
        req_addr  = m_bus.m_addr_i[m*ADDR_W +: ADDR_W];
        req_wdata = m_bus.m_data_i[m*DATA_W +: DATA_W];
        req_we    = m_bus.m_we_i[m];
        req_sel   = m_bus.m_sel_i[m*StrbW +: StrbW];
      end
    end
  end

  assign sel_field = req_addr[SEL_HI:SEL_LO];
  assign req_hit   = 32'(sel_field) < NUM_SLAVES;

  always_comb begin
    req_dec = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      req_dec[s] = (32'(sel_field) == s);
    end
  end

  // Only the strobed slave can complete; stray acks fall out of the mask.
  assign ack_hit = |(s_bus.s_ack_i & stb_q);

  always_comb begin
    slv_rdata = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (stb_q[s]) begin
        slv_rdata = s_bus.s_data_i[s*DATA_W +: DATA_W];
      end
    end
  end

`ifdef BUS_XBAR_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Held at zero outside ACTIVE, so it restarts on every entry.
  assign tmo_d   = (state_q == StActive) ? tmo_q + 16'd1 : 16'd0;
  assign tmo_hit = (state_q == StActive) && ((32'(tmo_q) + 32'd1) >= TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    stb_d   = stb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          gidx_d  = arb_idx;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          sel_d   = req_sel;
          if (req_hit) begin
            stb_d   = req_dec;
            err_d   = 1'b0;
            rdata_d = '0;
            state_d = StActive;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
            state_d = StResp;
          end
        end
      end
      StActive: begin
        // A real ack beats a timeout landing in the same cycle.
        if (ack_hit) begin
          rdata_d = slv_rdata;
          err_d   = 1'b0;
          stb_d   = '0;
          state_d = StResp;
        end else if (tmo_hit) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          stb_d   = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        if ((32'(gidx_q) + 32'd1) >= NUM_MASTERS) begin
          ptr_d = '0;
        end else begin
          ptr_d = gidx_q + MIdxW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        stb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      stb_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      stb_q   <= stb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign s_bus.s_stb_o  = stb_q;
  assign s_bus.s_addr_o = addr_q;
  assign s_bus.s_data_o = wdata_q;
  assign s_bus.s_we_o   = we_q;
  assign s_bus.s_sel_o  = sel_q;

  assign m_bus.m_ack_o  = (state_q == StResp) ? gnt_q : '0;
  assign m_bus.m_err_o  = ((state_q == StResp) && err_q) ? gnt_q : '0;
  assign m_bus.m_data_o = (state_q == StResp) ? rdata_q : '0;

endmodule

// File: tb/tb_bus_xbar.sv
// Bench for bus_xbar: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_bus_xbar;
  import bus_xbar_pkg::*;

  localparam int unsigned NM  = 2;
  localparam int unsigned NS  = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned Tmo = 4;
  localparam logic [31:0] Err = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_xbar_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_xbar #(
    .NUM_MASTERS (NM),
    .NUM_SLAVES  (NS),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .SEL_HI      (31),
    .SEL_LO      (28),
    .TIMEOUT     (Tmo),
    .ERR_DATA    (Err)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .m_bus (bus),
    .s_bus (bus)
  );

  // Stimulus
  logic        m_stb   [NM];
  logic [31:0] m_addr  [NM];
  logic [31:0] m_wdata [NM];
  logic        m_we    [NM];
  logic [3:0]  m_sel   [NM];
  logic [NS-1:0] s_ack;
  logic [31:0] s_rdata [NS];

  int unsigned slv_tab [10] = '{SlvRam, SlvRom, SlvFlash, SlvVga, SlvUart, SlvUartStat,
                                SlvDigseg, SlvPs2, 8, 9};

  // Reference model: the transaction in flight, if any
  int          mdl_ptr, mdl_mst, mdl_slv, mdl_tmo;
  bit          mdl_wait, mdl_resp, mdl_err, mdl_we;
  logic [31:0] mdl_addr, mdl_wdata, mdl_rdata;
  logic [3:0]  mdl_sel;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] smp_stb, smp_ack, smp_err, smp_data, smp_addr, cur_exp_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_stb();
    return mdl_wait ? (32'd1 << mdl_slv) : 32'd0;
  endfunction
  function automatic logic [31:0] exp_ack();
    return mdl_resp ? (32'd1 << mdl_mst) : 32'd0;
  endfunction
  function automatic logic [31:0] exp_err();
    return (mdl_resp && mdl_err) ? (32'd1 << mdl_mst) : 32'd0;
  endfunction
  function automatic logic [31:0] exp_mdata();
    return mdl_resp ? mdl_rdata : 32'd0;
  endfunction

  task automatic model_clear();
    mdl_ptr = 0; mdl_mst = 0; mdl_slv = 0; mdl_tmo = 0;
    mdl_wait = 0; mdl_resp = 0; mdl_err = 0; mdl_we = 0;
    mdl_addr = 0; mdl_wdata = 0; mdl_rdata = 0; mdl_sel = 0;
  endtask

  // What the bus does at one clock edge, given the inputs of the cycle that ends there.
  task automatic model_edge();
    bit found;
    int m;
    if (rst) begin
      model_clear();
    end else if (mdl_resp) begin
      mdl_resp = 0;
      mdl_ptr  = (mdl_mst + 1) % NM;
    end else if (mdl_wait) begin
      if (((s_ack >> mdl_slv) & 1) != 0) begin
        mdl_rdata = s_rdata[mdl_slv];
        mdl_err   = 0;
        mdl_wait  = 0;
        mdl_resp  = 1;
      end else begin
`ifdef BUS_XBAR_TIMEOUT_EN
        mdl_tmo++;
        if (mdl_tmo >= int'(Tmo)) begin
          mdl_rdata = Err;
          mdl_err   = 1;
          mdl_wait  = 0;
          mdl_resp  = 1;
        end
`endif
      end
    end else begin
      found = 0;
      for (int k = 0; k < NM; k++) begin
        m = (mdl_ptr + k) % NM;
        if (!found && m_stb[m]) begin
          found     = 1;
          mdl_mst   = m;
          mdl_addr  = m_addr[m];
          mdl_wdata = m_wdata[m];
          mdl_we    = m_we[m];
          mdl_sel   = m_sel[m];
          mdl_slv   = int'(m_addr[m][31:28]);
          mdl_tmo   = 0;
          if (mdl_slv < NS) begin
            mdl_wait = 1;
          end else begin
            mdl_resp  = 1;
            mdl_err   = 1;
            mdl_rdata = Err;
          end
        end
      end
    end
  endtask

  task automatic apply();
    for (int m = 0; m < NM; m++) begin
      bus.m_stb_i[m]           = m_stb[m];
      bus.m_addr_i[m*AW +: AW] = m_addr[m];
      bus.m_data_i[m*DW +: DW] = m_wdata[m];
      bus.m_we_i[m]            = m_we[m];
      bus.m_sel_i[m*4 +: 4]    = m_sel[m];
    end
    bus.s_ack_i = s_ack;
    for (int s = 0; s < NS; s++) bus.s_data_i[s*DW +: DW] = s_rdata[s];
  endtask

  // One clock: present inputs, compare at the falling edge, advance the model at the rise.
  task automatic cycle();
    apply();
    @(negedge clk);
    smp_stb     = 32'(bus.s_stb_o);
    smp_ack     = 32'(bus.m_ack_o);
    smp_err     = 32'(bus.m_err_o);
    smp_data    = bus.m_data_o;
    smp_addr    = bus.s_addr_o;
    cur_exp_ack = exp_ack();
    chk("s_stb_o", smp_stb, exp_stb());
    chk("m_ack_o", smp_ack, exp_ack());
    chk("m_err_o", smp_err, exp_err());
    chk("m_data_o", smp_data, exp_mdata());
    chk("s_addr_o", smp_addr, mdl_addr);
    chk("s_data_o", bus.s_data_o, mdl_wdata);
    chk("s_we_sel", {27'd0, bus.s_we_o, bus.s_sel_o}, {27'd0, mdl_we, mdl_sel});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < NM; m++) begin
      m_stb[m] = 0; m_addr[m] = 0; m_wdata[m] = 0; m_we[m] = 0; m_sel[m] = 0;
    end
    s_ack = '0;
    for (int s = 0; s < NS; s++) s_rdata[s] = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic new_request(input int m);
    logic [31:0] r;
    logic [3:0]  slv;
    r         = $urandom;
    slv       = 4'(slv_tab[$urandom_range(0, 9)]);
    m_stb[m]  = 1;
    m_addr[m] = {slv, r[27:0]};
    m_wdata[m] = $urandom;
    m_we[m]   = r[0];
    m_sel[m]  = r[7:4];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] grants [$];
    logic [31:0] alt [4];
    int          n_stb;
    bit          done;

    model_clear();
    do_reset();
    chk("rst_stb", smp_stb, 32'd0);
    chk("rst_ack", smp_ack, 32'd0);
    chk("rst_addr", smp_addr, 32'd0);

    // Single read from RAM, slave acks in the strobe cycle.
    m_stb[0] = 1; m_addr[0] = 32'h0000_0010; m_we[0] = 0; m_sel[0] = 4'hF;
    cycle();
    chk("t1_c0_stb", smp_stb, 32'd0);
    s_ack = 8'(1 << SlvRam); s_rdata[SlvRam] = 32'h1234_5678;
    cycle();
    chk("t1_c1_stb", smp_stb, 32'h1);
    s_ack = '0;
    cycle();
    chk("t1_ack", smp_ack, 32'h1);
    chk("t1_data", smp_data, 32'h1234_5678);
    chk("t1_err", smp_err, 32'h0);
    m_stb[0] = 0;
    cycle();
    chk("t1_c3_ack", smp_ack, 32'h0);

    // Unmapped write from master 1 (index 9).
    m_stb[1] = 1; m_addr[1] = 32'h9000_0000; m_we[1] = 1; m_wdata[1] = 32'hA5A5_0001;
    m_sel[1] = 4'h3;
    cycle();
    cycle();
    chk("t3_ack", smp_ack, 32'h2);
    chk("t3_err", smp_err, 32'h2);
    chk("t3_data", smp_data, 32'hDEAD_BEEF);
    chk("t3_stb", smp_stb, 32'h0);
    m_stb[1] = 0;
    cycle();

    // Both masters hammer ROM; grants must alternate.
    do_reset();
    alt = '{32'h1, 32'h2, 32'h1, 32'h2};
    for (int m = 0; m < NM; m++) begin
      m_stb[m] = 1; m_addr[m] = 32'h1000_0000 + 32'(m * 4); m_sel[m] = 4'hF;
    end
    s_ack = 8'(1 << SlvRom); s_rdata[SlvRom] = 32'h0000_1111;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (smp_ack != 0) grants.push_back(smp_ack);
    end
    chk("t2_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_grant", (i < grants.size()) ? grants[i] : 32'd0, alt[i]);
    idle_inputs();
    cycle();

    // Stray VGA acks while FLASH is selected are ignored.
    m_stb[0] = 1; m_addr[0] = 32'h2000_0040; m_sel[0] = 4'hF;
    cycle();
    s_ack = 8'(1 << SlvVga); s_rdata[SlvVga] = 32'hBAD0_0003; s_rdata[SlvFlash] = 32'hCAFE_0002;
    cycle();
    chk("t6_c1_stb", smp_stb, 32'h4);
    cycle();
    chk("t6_c2_ack", smp_ack, 32'h0);
    chk("t6_c2_stb", smp_stb, 32'h4);
    s_ack = 8'(1 << SlvFlash);
    cycle();
    chk("t6_c3_ack", smp_ack, 32'h0);
    s_ack = '0;
    cycle();
    chk("t6_ack", smp_ack, 32'h1);
    chk("t6_data", smp_data, 32'hCAFE_0002);
    m_stb[0] = 0;
    cycle();

    // Reset while ACTIVE, late ack afterwards.
    m_stb[0] = 1; m_addr[0] = 32'h0100_0000;
    cycle();
    cycle();
    chk("t4_active_stb", smp_stb, 32'h1);
    rst = 1; m_stb[0] = 0;
    cycle();
    rst = 0;
    cycle();
    chk("t4_stb", smp_stb, 32'h0);
    chk("t4_addr", smp_addr, 32'h0);
    s_ack = 8'(1 << SlvRam); s_rdata[SlvRam] = 32'h7777_7777;
    cycle();
    chk("t4_late_ack", smp_ack, 32'h0);
    s_ack = '0;
    cycle();
    chk("t4_ack", smp_ack, 32'h0);
    chk("t4_data", smp_data, 32'h0);

`ifdef BUS_XBAR_TIMEOUT_EN
    // UART never answers.
    m_stb[0] = 1; m_addr[0] = 32'h4000_0000;
    n_stb = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      cycle();
      if (smp_stb != 0) n_stb++;
      if (smp_ack != 0) done = 1;
    end
    chk("tmo_stb_cycles", 32'(n_stb), Tmo);
    chk("tmo_ack", smp_ack, 32'h1);
    chk("tmo_err", smp_err, 32'h1);
    chk("tmo_data", smp_data, 32'hDEAD_BEEF);
    m_stb[0] = 0;
    cycle();
`else
    n_stb = 0; done = 0;
`endif

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int s = 0; s < NS; s++) begin
        s_ack[s]   = ($urandom_range(0, 99) < 40);
        s_rdata[s] = $urandom;
      end
      cycle();
      for (int m = 0; m < NM; m++) begin
        if (rst || cur_exp_ack[m]) m_stb[m] = 0;
        if (!m_stb[m] && $urandom_range(0, 99) < 50) new_request(m);
      end
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
